// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel/line counters with registered sync, blank and frame-start decode.
// Optional macro VGA_SYNC_ALIGN_EN adds a 2-stage pix_ce-gated delay on hs/vs/blank (exported blank_d).
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic       pix_ce,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic       frame_start
`ifdef VGA_SYNC_ALIGN_EN
  ,
  output logic       blank_d
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] x_reg;
  logic [9:0] x_next;
  logic [9:0] y_reg;
  logic [9:0] y_next;
  logic       hs_reg;
  logic       hs_next;
  logic       vs_reg;
  logic       vs_next;
  logic       blank_reg;
  logic       blank_next;
  logic       fs_reg;
  logic       fs_next;

  // Counter advance; any value at or past the last legal count wraps to 0.
  always_comb begin
    x_next = x_reg;
    y_next = y_reg;
    if (x_reg >= H_LAST) begin
      x_next = '0;
      if (y_reg >= V_LAST) begin
        y_next = '0;
      end else begin
        y_next = y_reg + 10'd1;
      end
    end else begin
      x_next = x_reg + 10'd1;
    end
    if (y_reg > V_LAST) begin
      y_next = '0;
    end
  end

  // Decode from the next counter values so the registered flags line up with DrawX/DrawY.
  always_comb begin
    hs_next    = ~((x_next >= HS_START) && (x_next < HS_END));
    vs_next    = ~((y_next >= VS_START) && (y_next < VS_END));
    blank_next = (x_next < H_VIS) && (y_next < V_VIS);
    fs_next    = (x_next == '0) && (y_next == '0);
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      x_reg     <= '0;
      y_reg     <= '0;
      hs_reg    <= 1'b1;
      vs_reg    <= 1'b1;
      blank_reg <= 1'b1;
      fs_reg    <= 1'b1;
    end else if (pix_ce) begin
      x_reg     <= x_next;
      y_reg     <= y_next;
      hs_reg    <= hs_next;
      vs_reg    <= vs_next;
      blank_reg <= blank_next;
      fs_reg    <= fs_next;
    end
  end

  assign DrawX       = x_reg;
  assign DrawY       = y_reg;
  assign frame_start = fs_reg;
  assign blank       = blank_reg;

`ifdef VGA_SYNC_ALIGN_EN
  // Delay line matching the mappers' ROM-plus-register RGB latency; each entry is {hs, vs, blank}.
  localparam int ALIGN_STAGES = 2;
  logic [2:0] align_reg [ALIGN_STAGES];

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      for (int i = 0; i < ALIGN_STAGES; i++) begin
        align_reg[i] <= 3'b111;
      end
    end else if (pix_ce) begin
      align_reg[0] <= {hs_reg, vs_reg, blank_reg};
      for (int i = 1; i < ALIGN_STAGES; i++) begin
        align_reg[i] <= align_reg[i-1];
      end
    end
  end

  assign hs      = align_reg[ALIGN_STAGES-1][2];
  assign vs      = align_reg[ALIGN_STAGES-1][1];
  assign blank_d = align_reg[ALIGN_STAGES-1][0];
`else
  assign hs = hs_reg;
  assign vs = vs_reg;
`endif

endmodule
